ow_data_writer: RTL and testbench
=================================

# ow_data_writer

Master-side 1-Wire write-slot generator, the transmit counterpart of the 64-bit data reader. It serialises a latched data word LSB-first onto the open-drain 1-Wire bus using fixed-length time slots, and checks each write-1 slot for a slave holding the line low. The 1-Wire top level instantiates it beside the reader, sharing the bus and the slot timing constants.

## Interface
- WIDTH, 64: bits per transfer.
- SLOT_CYCLES, 60: active slot length in clk cycles; matches the reader's slot.
- LOW1_CYCLES, 6: cycles held low for a write-1.
- LOW0_CYCLES, 56: cycles held low for a write-0.
- SAMPLE_AT, 30: slot cycle at which bus_in is checked in write-1 slots; matches the reader's sample point.
- REC_CYCLES, 2: released recovery cycles after each slot.
- Legal parameter range: 1 ≤ LOW1_CYCLES < SAMPLE_AT < LOW0_CYCLES < SLOT_CYCLES, and REC_CYCLES ≥ 1.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en_data_write  in  1  start request; sampled only in IDLE.
- data  in  WIDTH  word to send; latched on the start edge.
- bus_in  in  1  resolved bus level.
- bus_drive_low  out  1  1 = pull the bus low. Top level uses bus = bus_drive_low ? 0 : z.
- busy  out  1  transfer in progress.
- done_writing_data  out  1  one-cycle pulse after the last recovery.
- collision  out  1  sticky flag: a write-1 slot saw bus_in = 0 at SAMPLE_AT.

## Operation
- States are IDLE, SLOT, and RECOVERY.
- IDLE:
  - On en_data_write = 1: latch data into the shift register, clear collision, set cnt = 0 and bit_idx = 0, then enter SLOT.
  - en_data_write held high re-triggers only once the block is back in IDLE.
- SLOT (cnt runs 0..SLOT_CYCLES-1):
  - bus_drive_low = 1 while cnt < LOWx. LOWx is LOW1_CYCLES when shreg[0] = 1, otherwise LOW0_CYCLES.
  - At cnt = SAMPLE_AT with shreg[0] = 1 and bus_in = 0: set collision.
  - At cnt = SLOT_CYCLES-1: go to RECOVERY with cnt = 0.
- RECOVERY (cnt runs 0..REC_CYCLES-1):
  - bus released.
  - On the last cycle: shift shreg right and increment bit_idx.
  - If bit_idx was WIDTH-1: pulse done_writing_data and go to IDLE.
  - Otherwise: go to SLOT with cnt = 0.
- The bit order matches the reader: bit 0 goes out first and lands in memory[0].
- en_data_write is ignored while busy; data changes after the start edge have no effect.
- Width rules: cnt is clog2(SLOT_CYCLES) bits; bit_idx is clog2(WIDTH)+1 bits; no arithmetic wraps inside a transfer.

## Timing
- Reset values: bus_drive_low = 0, busy = 0, done_writing_data = 0, collision = 0, state IDLE, counters 0.
- All outputs are registered.
- Start accepted at edge t:
  - busy = 1 and bus_drive_low = 1 from cycle t+1.
  - Each bit takes SLOT_CYCLES + REC_CYCLES = 62 cycles.
- done_writing_data is high for exactly cycle t+1+WIDTH×62, which is t+3969 for the defaults.
  - busy drops in that same cycle.
  - A new start is accepted on that cycle's edge.
- Low pulse widths are exactly LOW1_CYCLES or LOW0_CYCLES cycles, with the falling edge at slot cnt = 0.
- Reset mid-transfer: at the next edge the bus is released, the block returns to IDLE, collision is cleared, and no done pulse is issued.
- collision stays valid from its setting cycle until the next accepted start or reset.

## Structure
- Shared package ow_pkg holds:
  - the slot timing constants (SLOT_CYCLES, SAMPLE_AT, LOW1/LOW0, REC), used by both the reader and this writer;
  - the writer state enum (IDLE, SLOT, RECOVERY).
- One natural sub-module, ow_slot_timer: a per-slot cycle counter with slot_end and rec_end strobes, reusable by the reader.
- Shift register, bit counter, and FSM stay in ow_data_writer.

## Test plan
- data = 64'h1, start once. Required: bit 0 low for 6 cycles; bits 1..63 low for 56 cycles each; 62-cycle slot spacing; done exactly 3969 cycles after the start edge.
- data = 64'hA5A5_0000_FFFF_1234, with a reader model sampling at cycle 30. Required: the reader's memory equals data exactly and collision = 0.
- Force bus_in = 0 during bit 4's write-1 slot, cycles 25..35. Required: collision = 1 from SAMPLE_AT+1 onward; the transfer still completes.
- Pulse en_data_write again 100 cycles into a transfer. Required: it is ignored; exactly one done pulse, at 3969.
- Assert rst at cycle 1000. Required: bus_drive_low = 0 and busy = 0 at the next edge, no done pulse; a fresh start afterwards behaves as the first scenario.
- Hold en_data_write high continuously. Required: back-to-back transfers, with the next start accepted on the done cycle and new data latched there.

Source files
------------

// File: rtl/ow_pkg.sv
// Shared 1-Wire package.
// Holds the slot timing constants used by both the data reader and the
// data writer, plus the writer FSM state encoding.
package ow_pkg;

   localparam int OW_WIDTH       = 64;  // bits per transfer
   localparam int OW_SLOT_CYCLES = 60;  // active slot length in clk cycles
   localparam int OW_LOW1_CYCLES = 6;   // low time for a write-1
   localparam int OW_LOW0_CYCLES = 56;  // low time for a write-0
   localparam int OW_SAMPLE_AT   = 30;  // slot cycle at which the bus is sampled
   localparam int OW_REC_CYCLES  = 2;   // released recovery cycles after each slot

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SLOT,
      ST_RECOVERY
   } wr_state_e;

endpackage

// File: rtl/ow_slot_timer.sv
// Per-slot cycle counter for the 1-Wire slot generators.
// The counter restarts from 0 whenever clear is high and otherwise counts up
// by one each cycle. The owner decides when to clear.
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous, active-high reset
//   clear    in   load 0 on the next edge instead of incrementing
//   cnt      out  current slot cycle
//   cnt_nxt  out  value cnt takes at the next edge (lets owners register
//                 outputs that depend on the upcoming count)
//   slot_end out  cnt is on the last active-slot cycle
//   rec_end  out  cnt is on the last recovery cycle
module ow_slot_timer #(
   parameter int SLOT_CYCLES = 60,
   parameter int REC_CYCLES  = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           clear,
   output logic [$clog2(SLOT_CYCLES)-1:0] cnt,
   output logic [$clog2(SLOT_CYCLES)-1:0] cnt_nxt,
   output logic                           slot_end,
   output logic                           rec_end
);

   localparam int CW = $clog2(SLOT_CYCLES);

   always_comb begin
      cnt_nxt = clear ? '0 : cnt + CW'(1);
   end

   // NOTE: sequential state always uses non-blocking assignments so every
   // register samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst) cnt <= '0;
      else     cnt <= cnt_nxt;
   end

   assign slot_end = (cnt == CW'(SLOT_CYCLES - 1));
   assign rec_end  = (cnt == CW'(REC_CYCLES - 1));

endmodule

// File: rtl/ow_data_writer.sv
// Master-side 1-Wire write-slot generator.
// Sends a latched WIDTH-bit word LSB-first in fixed-length slots: a write-1
// holds the bus low for LOW1_CYCLES, a write-0 for LOW0_CYCLES, each slot
// followed by REC_CYCLES of released recovery. Write-1 slots sample the bus
// at SAMPLE_AT and raise a sticky collision flag if a slave holds it low.
// Ports:
//   clk               in   system clock, rising edge
//   rst               in   synchronous, active-high reset
//   en_data_write     in   start request, honoured only when idle
//   data              in   word to send, latched on the start edge
//   bus_in            in   resolved bus level
//   bus_drive_low     out  1 = pull the bus low (open drain)
//   busy              out  transfer in progress
//   done_writing_data out  one-cycle pulse after the last recovery
//   collision         out  sticky: a write-1 slot saw the bus low at SAMPLE_AT
module ow_data_writer
   import ow_pkg::*;
#(
   parameter int WIDTH       = OW_WIDTH,
   parameter int SLOT_CYCLES = OW_SLOT_CYCLES,
   parameter int LOW1_CYCLES = OW_LOW1_CYCLES,
   parameter int LOW0_CYCLES = OW_LOW0_CYCLES,
   parameter int SAMPLE_AT   = OW_SAMPLE_AT,
   parameter int REC_CYCLES  = OW_REC_CYCLES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_data_write,
   input  logic [WIDTH-1:0] data,
   input  logic             bus_in,
   output logic             bus_drive_low,
   output logic             busy,
   output logic             done_writing_data,
   output logic             collision
);

   localparam int CW = $clog2(SLOT_CYCLES);
   localparam int BW = $clog2(WIDTH) + 1;

   localparam logic [CW-1:0] LOW1_C   = CW'(LOW1_CYCLES);
   localparam logic [CW-1:0] LOW0_C   = CW'(LOW0_CYCLES);
   localparam logic [CW-1:0] SAMPLE_C = CW'(SAMPLE_AT);
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

   wr_state_e        state, state_d;
   logic [WIDTH-1:0] shreg, shreg_d;
   logic [BW-1:0]    bit_idx, bit_idx_d;
   logic             collision_d, done_d, drive_d, busy_d;
   logic             timer_clear;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic             slot_end, rec_end;

   ow_slot_timer #(
      .SLOT_CYCLES (SLOT_CYCLES),
      .REC_CYCLES  (REC_CYCLES)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .clear    (timer_clear),
      .cnt      (cnt),
      .cnt_nxt  (cnt_nxt),
      .slot_end (slot_end),
      .rec_end  (rec_end)
   );

   // NOTE: every signal written here gets a default first, so no path
   // through the case can leave one unassigned and infer a latch.
   always_comb begin
      state_d     = state;
      shreg_d     = shreg;
      bit_idx_d   = bit_idx;
      collision_d = collision;
      done_d      = 1'b0;

      case (state)
         ST_IDLE: begin
            if (en_data_write) begin
               shreg_d     = data;
               bit_idx_d   = '0;
               collision_d = 1'b0;
               state_d     = ST_SLOT;
            end
         end
         ST_SLOT: begin
            if (cnt == SAMPLE_C && shreg[0] && !bus_in) collision_d = 1'b1;
            if (slot_end) state_d = ST_RECOVERY;
         end
         ST_RECOVERY: begin
            if (rec_end) begin
               shreg_d   = shreg >> 1;
               bit_idx_d = bit_idx + BW'(1);
               if (bit_idx == LAST_BIT) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_SLOT;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Every phase change restarts the slot counter at 0; idle holds it there.
      timer_clear = (state_d != state) || (state == ST_IDLE);

      // Outputs are registered, so they are computed from the upcoming state,
      // count and bit; this puts the falling edge exactly at slot cnt = 0.
      drive_d = (state_d == ST_SLOT) &&
                (cnt_nxt < (shreg_d[0] ? LOW1_C : LOW0_C));
      busy_d  = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= ST_IDLE;
         shreg             <= '0;
         bit_idx           <= '0;
         bus_drive_low     <= 1'b0;
         busy              <= 1'b0;
         done_writing_data <= 1'b0;
         collision         <= 1'b0;
      end else begin
         state             <= state_d;
         shreg             <= shreg_d;
         bit_idx           <= bit_idx_d;
         bus_drive_low     <= drive_d;
         busy              <= busy_d;
         done_writing_data <= done_d;
         collision         <= collision_d;
      end
   end

endmodule

// File: tb/tb_ow_data_writer.sv
// Self-checking bench for ow_data_writer: open-drain bus model, a reader
// model sampling at slot cycle 30, and a scoreboard of expected words.
module tb_ow_data_writer;

   localparam int W        = 64;
   localparam int SLOT     = 60;
   localparam int REC      = 2;
   localparam int LOW1     = 6;
   localparam int LOW0     = 56;
   localparam int SAMPLE   = 30;
   localparam int BIT_T    = SLOT + REC;   // 62
   localparam int XFER_T   = W * BIT_T;    // done cycle relative to first busy cycle

   logic         clk = 1'b0;
   logic         rst;
   logic         en_data_write;
   logic [W-1:0] data;
   logic         bus_in;
   logic         bus_drive_low;
   logic         busy;
   logic         done_writing_data;
   logic         collision;
   logic         force_low;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   logic [W-1:0] exp_q[$];

   // Monitor / reader model state
   int           idx = 0;
   int           cur_fall = -1000;
   int           fall_cyc[W];
   int           width[W];
   logic [W-1:0] mon_word = '0;
   int           done_cnt = 0;
   logic         prev_drive = 1'b0;
   logic         prev_busy = 1'b0;

   ow_data_writer dut (
      .clk               (clk),
      .rst               (rst),
      .en_data_write     (en_data_write),
      .data              (data),
      .bus_in            (bus_in),
      .bus_drive_low     (bus_drive_low),
      .busy              (busy),
      .done_writing_data (done_writing_data),
      .collision         (collision)
   );

   assign bus_in = !(bus_drive_low || force_low);

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (busy === 1'b1 && prev_busy !== 1'b1) begin
         idx      = 0;
         mon_word = '0;
      end
      if (bus_drive_low === 1'b1 && prev_drive !== 1'b1 && idx < W) begin
         fall_cyc[idx] = cyc;
         cur_fall      = cyc;
         idx++;
      end
      if (bus_drive_low === 1'b0 && prev_drive === 1'b1 && idx > 0)
         width[idx-1] = cyc - cur_fall;
      if (idx > 0 && cyc == cur_fall + SAMPLE)
         mon_word[idx-1] = bus_in;
      if (done_writing_data === 1'b1) done_cnt++;
      prev_drive = bus_drive_low;
      prev_busy  = busy;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   // Request a start; s returns the first busy cycle (the start edge is s-1).
   task automatic start_xfer(input logic [W-1:0] d, input bit hold, output int s);
      @(negedge clk);
      data          = d;
      en_data_write = 1'b1;
      @(negedge clk);
      s = cyc;
      if (!hold) en_data_write = 1'b0;
      check("start_busy", busy, 1);
      check("start_drive", bus_drive_low, 1);
      check("start_coll_clr", collision, 0);
   endtask

   task automatic wait_done(output int dc);
      int n = 0;
      dc = -1;
      while (done_writing_data !== 1'b1 && n < 2 * XFER_T) begin
         @(negedge clk);
         n++;
      end
      check("done_seen", done_writing_data, 1);
      if (done_writing_data === 1'b1) dc = cyc;
   endtask

   // Pops the scoreboard and checks timing, pulse widths and the read word.
   task automatic verify(input int s, input int dc, input logic [W-1:0] sent);
      logic [W-1:0] exp_word;
      exp_word = exp_q.pop_front();
      check("done_time", dc, s + XFER_T);
      check("done_busy_low", busy, 0);
      check("reader_word", mon_word, exp_word);
      check("slot_count", idx, W);
      for (int k = 0; k < W; k++) begin
         check($sformatf("fall_%0d", k), fall_cyc[k], s + k * BIT_T);
         check($sformatf("width_%0d", k), width[k], sent[k] ? LOW1 : LOW0);
      end
   endtask

   initial begin
      int s, s2, dc, dc2, d0;
      logic [W-1:0] d;

      rst = 1'b1; en_data_write = 1'b0; data = '0; force_low = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_drive", bus_drive_low, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done_writing_data, 0);
      check("rst_coll", collision, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Single 1: one short pulse then 63 long pulses.
      d = 64'h1;
      exp_q.push_back(d);
      start_xfer(d, 0, s);
      wait_done(dc);
      verify(s, dc, d);

      // Mixed pattern read back by the reader model.
      d = 64'hA5A5_0000_FFFF_1234;
      exp_q.push_back(d);
      start_xfer(d, 0, s);
      wait_done(dc);
      verify(s, dc, d);
      check("no_collision", collision, 0);

      // Slave holds the bus low during bit 4 (a write-1), cycles 25..35.
      exp_q.push_back(d & ~64'h10);
      start_xfer(d, 0, s);
      wait_cyc(s + 4 * BIT_T + 25);
      force_low = 1'b1;
      wait_cyc(s + 4 * BIT_T + SAMPLE);
      check("coll_before", collision, 0);
      wait_cyc(s + 4 * BIT_T + SAMPLE + 1);
      check("coll_after", collision, 1);
      wait_cyc(s + 4 * BIT_T + 36);
      force_low = 1'b0;
      wait_done(dc);
      verify(s, dc, d);
      check("coll_sticky", collision, 1);

      // Start pulse mid-transfer with different data is ignored.
      d = 64'h0123_4567_89AB_CDEF;
      exp_q.push_back(d);
      start_xfer(d, 0, s);
      d0 = done_cnt;
      wait_cyc(s + 100);
      data = 64'hFFFF_FFFF_FFFF_FFFF;
      en_data_write = 1'b1;
      @(negedge clk);
      en_data_write = 1'b0;
      wait_done(dc);
      verify(s, dc, d);
      repeat (5) @(negedge clk);
      check("one_done", done_cnt - d0, 1);
      check("idle_after", busy, 0);

      // Reset in the middle of a transfer.
      start_xfer(64'hDEAD_BEEF_0000_0001, 0, s);
      d0 = done_cnt;
      wait_cyc(s + 999);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_drive", bus_drive_low, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done_writing_data, 0);
      check("mid_rst_coll", collision, 0);
      rst = 1'b0;
      repeat (100) @(negedge clk);
      check("no_done_after_rst", done_cnt - d0, 0);
      check("idle_after_rst", busy, 0);

      // Fresh start after reset behaves like the first transfer.
      d = 64'h1;
      exp_q.push_back(d);
      start_xfer(d, 0, s);
      wait_done(dc);
      verify(s, dc, d);

      // Held request: back-to-back transfers, new data latched on the done cycle.
      d = 64'hF0F0_1234_5678_0F0F;
      exp_q.push_back(d);
      exp_q.push_back(64'h8000_0000_C3C3_0001);
      start_xfer(d, 1, s);
      wait_cyc(s + 10);
      data = 64'h8000_0000_C3C3_0001;
      wait_done(dc);
      verify(s, dc, d);
      @(negedge clk);
      s2 = cyc;
      en_data_write = 1'b0;
      check("b2b_restart_cyc", s2, dc + 1);
      check("b2b_busy", busy, 1);
      check("b2b_drive", bus_drive_low, 1);
      wait_done(dc2);
      verify(s2, dc2, 64'h8000_0000_C3C3_0001);
      repeat (5) @(negedge clk);
      check("final_idle", busy, 0);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
